// File: rtl/instr_fetch_reg.sv
// Instruction fetch sequencer and instruction register for the multicycle RV64 core.
// Issues one instruction-memory read per fetch request and exposes the decoded IR fields.
module instr_fetch_reg #(
    parameter int          XLEN        = 64,
    parameter int          TIMEOUT_CYC = 15,
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic            ir_valid,
    output logic            busy,
    output logic            misalign,
    output logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

    state_t          state, state_nxt;
    logic [7:0]      wait_cnt, wait_cnt_nxt;
    logic [31:0]     ir, ir_nxt;
    logic [XLEN-1:0] addr_nxt;
    logic            rd_nxt;
    logic            valid_nxt;
    logic            misalign_nxt;
    logic            bus_err_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush always beats both a new request and data returning in the same cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ir_nxt       = ir;
        addr_nxt     = imem_addr;
        rd_nxt       = imem_rd;
        valid_nxt    = 1'b0;
        misalign_nxt = 1'b0;
        bus_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req && !flush) begin
                    if (pc[1:0] != 2'b00) begin
                        misalign_nxt = 1'b1;
                    end else begin
                        addr_nxt     = pc;
                        rd_nxt       = 1'b1;
                        wait_cnt_nxt = 8'd0;
                        state_nxt    = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    rd_nxt    = 1'b0;
                    state_nxt = IDLE;
                end else if (imem_ready) begin
                    ir_nxt    = imem_rdata;
                    rd_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    rd_nxt      = 1'b0;
                    bus_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            DONE: begin
                valid_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                rd_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 8'd0;
            ir        <= RESET_INSTR;
            imem_addr <= '0;
            imem_rd   <= 1'b0;
            ir_valid  <= 1'b0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_nxt;
            ir        <= ir_nxt;
            imem_addr <= addr_nxt;
            imem_rd   <= rd_nxt;
            ir_valid  <= valid_nxt;
            misalign  <= misalign_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

    assign busy   = (state == REQ) || (state == DONE);
    assign instr  = ir;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Transaction-level bench for instr_fetch_reg: each fetch outcome is predicted
// from its documented cycle timing and compared against the DUT.
module tb_instr_fetch_reg;

    localparam int          XLEN = 64;
    localparam int          T    = 15;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic            clk;
    logic            reset;
    logic            fetch_req;
    logic            flush;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rd;
    logic [31:0]     imem_rdata;
    logic            imem_ready;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic            ir_valid;
    logic            busy;
    logic            misalign;
    logic            bus_err;

    int errors = 0;
    int checks = 0;

    logic [31:0]     exp_ir;
    logic [XLEN-1:0] exp_addr;

    instr_fetch_reg #(.XLEN(XLEN), .TIMEOUT_CYC(T), .RESET_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .flush(flush), .pc(pc),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .instr(instr), .opcode(opcode), .rd(rd),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .ir_valid(ir_valid), .busy(busy), .misalign(misalign), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rand_aligned();
        logic [XLEN-1:0] a;
        a = {$urandom, $urandom};
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic chk_fields();
        chk("instr",  instr,  exp_ir);
        chk("opcode", opcode, exp_ir[6:0]);
        chk("rd",     rd,     exp_ir[11:7]);
        chk("funct3", funct3, exp_ir[14:12]);
        chk("rs1",    rs1,    exp_ir[19:15]);
        chk("rs2",    rs2,    exp_ir[24:20]);
        chk("funct7", funct7, exp_ir[31:25]);
    endtask

    // Accepts a request at pc=a; afterwards the DUT has been in REQ for one cycle.
    task automatic enter_req(input logic [XLEN-1:0] a);
        fetch_req = 1'b1; flush = 1'b0; pc = a; imem_ready = 1'b0; imem_rdata = $urandom;
        cyc();
        exp_addr = a;
        chk("req_rd",   imem_rd,   1'b1);
        chk("req_addr", imem_addr, a);
        chk("req_busy", busy,      1'b1);
        chk("req_vld",  ir_valid,  1'b0);
        chk("req_mis",  misalign,  1'b0);
        chk("req_err",  bus_err,   1'b0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            fetch_req = 1'($urandom_range(0, 1)); pc = rand_aligned();
            imem_ready = 1'b0; imem_rdata = $urandom;
            cyc();
            chk("wait_rd",   imem_rd,   1'b1);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_busy", busy,      1'b1);
            chk("wait_err",  bus_err,   1'b0);
        end
    endtask

    // Ready arrives k cycles after imem_rd rises: DONE after k+1 edges, ir_valid after k+2.
    task automatic do_fetch(input logic [XLEN-1:0] a, input int k, input logic [31:0] data);
        enter_req(a);
        wait_cycles(k);
        fetch_req = 1'b0; imem_ready = 1'b1; imem_rdata = data;
        cyc();
        exp_ir = data;
        chk("done_ir",   instr,    exp_ir);
        chk("done_rd",   imem_rd,  1'b0);
        chk("done_busy", busy,     1'b1);
        chk("done_vld",  ir_valid, 1'b0);
        // This request lands in DONE and must be dropped.
        fetch_req = 1'b1; pc = rand_aligned(); imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        cyc();
        chk("vld",       ir_valid,  1'b1);
        chk("vld_busy",  busy,      1'b0);
        chk("vld_rd",    imem_rd,   1'b0);
        chk("vld_addr",  imem_addr, exp_addr);
        chk_fields();
        fetch_req = 1'b0; imem_ready = 1'b0;
    endtask

    task automatic do_misalign(input logic [XLEN-1:0] a);
        fetch_req = 1'b1; flush = 1'b0; pc = a; imem_ready = 1'b0;
        cyc();
        chk("mis_pulse", misalign,  1'b1);
        chk("mis_rd",    imem_rd,   1'b0);
        chk("mis_busy",  busy,      1'b0);
        chk("mis_vld",   ir_valid,  1'b0);
        chk("mis_ir",    instr,     exp_ir);
        chk("mis_addr",  imem_addr, exp_addr);
        fetch_req = 1'b0;
        cyc();
        chk("mis_end",   misalign,  1'b0);
        chk("mis_rd2",   imem_rd,   1'b0);
    endtask

    task automatic do_timeout(input logic [XLEN-1:0] a);
        enter_req(a);
        for (int i = 1; i <= T; i++) begin
            fetch_req = 1'($urandom_range(0, 1)); pc = rand_aligned(); imem_ready = 1'b0;
            cyc();
            if (i < T) begin
                chk("to_rd",  imem_rd, 1'b1);
                chk("to_err", bus_err, 1'b0);
            end else begin
                chk("to_err_pulse", bus_err,  1'b1);
                chk("to_rd_drop",   imem_rd,  1'b0);
                chk("to_busy",      busy,     1'b0);
                chk("to_vld",       ir_valid, 1'b0);
                chk("to_ir",        instr,    exp_ir);
            end
        end
        fetch_req = 1'b0;
        cyc();
        chk("to_err_end", bus_err,  1'b0);
        chk("to_vld2",    ir_valid, 1'b0);
    endtask

    task automatic do_flush_req(input logic [XLEN-1:0] a, input int j, input logic [31:0] data);
        enter_req(a);
        wait_cycles(j);
        fetch_req = 1'b0; flush = 1'b1; imem_ready = 1'($urandom_range(0, 1)); imem_rdata = data;
        cyc();
        chk("fl_rd",   imem_rd,  1'b0);
        chk("fl_busy", busy,     1'b0);
        chk("fl_ir",   instr,    exp_ir);
        chk("fl_vld",  ir_valid, 1'b0);
        chk("fl_err",  bus_err,  1'b0);
        flush = 1'b0; imem_ready = 1'b0;
        cyc();
        chk("fl_vld2", ir_valid, 1'b0);
        chk("fl_ir2",  instr,    exp_ir);
    endtask

    task automatic do_flush_idle(input logic [XLEN-1:0] a);
        fetch_req = 1'b1; flush = 1'b1; pc = a; imem_ready = 1'b0;
        cyc();
        chk("fi_rd",   imem_rd,   1'b0);
        chk("fi_busy", busy,      1'b0);
        chk("fi_mis",  misalign,  1'b0);
        chk("fi_addr", imem_addr, exp_addr);
        fetch_req = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; flush = 1'b0; pc = '0;
        imem_rdata = '0; imem_ready = 1'b0;
        exp_ir = NOP; exp_addr = '0;
        #2 reset = 1'b0;
        cyc(); cyc();
        #2 reset = 1'b1;
        cyc();
        chk("rst_instr",  instr,     NOP);
        chk("rst_opcode", opcode,    7'd19);
        chk("rst_vld",    ir_valid,  1'b0);
        chk("rst_rd",     imem_rd,   1'b0);
        chk("rst_busy",   busy,      1'b0);
        chk("rst_addr",   imem_addr, 64'h0);

        do_fetch(64'h40, 0, 32'h00A00093);
        chk("t2_opcode", opcode, 7'd19);
        chk("t2_rd",     rd,     5'd1);
        chk("t2_rs1",    rs1,    5'd0);
        do_misalign(64'h42);
        do_timeout(64'h80);
        do_fetch(64'h84, T - 1, 32'hDEADBEEF);
        do_flush_req(64'h100, 0, 32'hFE0008E3);
        do_flush_idle(64'h200);

        // Asynchronous reset in the middle of an outstanding request.
        do_fetch(64'h300, 2, 32'h12345678);
        enter_req(64'h304);
        wait_cycles(1);
        #2 reset = 1'b0;
        #1;
        chk("arst_instr", instr,     NOP);
        chk("arst_rd",    imem_rd,   1'b0);
        chk("arst_busy",  busy,      1'b0);
        chk("arst_addr",  imem_addr, 64'h0);
        exp_ir = NOP; exp_addr = '0;
        cyc();
        #3 reset = 1'b1;
        cyc();
        chk("arst_idle_rd", imem_rd, 1'b0);
        do_fetch(64'h8, 1, 32'h00B50533);

        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 11));
            if (op <= 4)
                do_fetch(rand_aligned(), int'($urandom_range(0, T - 1)), $urandom);
            else if (op <= 6)
                do_misalign(rand_aligned() | 64'($urandom_range(1, 3)));
            else if (op == 7)
                do_timeout(rand_aligned());
            else if (op <= 9)
                do_flush_req(rand_aligned(), int'($urandom_range(0, T - 2)), $urandom);
            else
                do_flush_idle({$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
